// File: rtl/siphash_stream_core.sv
// Streaming SipHash-C-D engine: absorbs 64-bit LE words, builds the length block, finalises to 64/128 bits.
// Optional SIPHASH_BLOCK_CTR_EN adds a saturating processed-block counter on blk_cnt.
module siphash_stream_core #(
  parameter int unsigned C_ROUNDS = 2,
  parameter int unsigned D_ROUNDS = 4,
  parameter int unsigned RPC      = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         long,
  input  logic [127:0] key,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [63:0]  msg_data,
  input  logic         msg_last,
  input  logic [2:0]   msg_bytes,
  output logic         busy,
  output logic [127:0] digest,
  output logic         digest_valid
`ifdef SIPHASH_BLOCK_CTR_EN
  ,
  output logic [31:0]  blk_cnt
`endif
);

  if (C_ROUNDS == 0 || C_ROUNDS > 15 || D_ROUNDS == 0 || D_ROUNDS > 15 ||
      (RPC != 1 && RPC != 2)) begin : g_bad_param
    $error("siphash_stream_core: illegal C_ROUNDS/D_ROUNDS/RPC");
  end

  typedef enum logic [3:0] {
    IDLE, ABSORB, COMP, MIX, FXOR, FIN, OUT0, OUT1, DONE
  } state_t;

  state_t        state_q, state_d;
  logic [63:0]   v0_q, v1_q, v2_q, v3_q;
  logic [63:0]   m_q;
  logic [7:0]    len_q;
  logic [3:0]    rem_q;
  logic          last_q, long_q, second_q;
  logic [127:0]  digest_q;
  logic          dv_q;

  logic [255:0]  r1, r2, rnd;
  logic          two, last_step, xfer;
  logic [3:0]    step;
  logic [63:0]   m_last, m_beat, vfin;

  function automatic logic [255:0] sip_round(input logic [255:0] s);
    logic [63:0] a, b, c, d;
    a = s[63:0];
    b = s[127:64];
    c = s[191:128];
    d = s[255:192];
    a = a + b;  b = {b[50:0], b[63:51]} ^ a;  a = {a[31:0], a[63:32]};
    c = c + d;  d = {d[47:0], d[63:48]} ^ c;
    a = a + d;  d = {d[42:0], d[63:43]} ^ a;
    c = c + b;  b = {b[46:0], b[63:47]} ^ c;  c = {c[31:0], c[63:32]};
    return {d, c, b, a};
  endfunction

  // With RPC=2 the second round is skipped when only one remains (odd round counts).
  always_comb begin
    r1        = sip_round({v3_q, v2_q, v1_q, v0_q});
    r2        = sip_round(r1);
    two       = (RPC == 2) && (rem_q >= 4'd2);
    rnd       = two ? r2 : r1;
    step      = two ? 4'd2 : 4'd1;
    last_step = (rem_q <= step);
    vfin      = v0_q ^ v1_q ^ v2_q ^ v3_q;
  end

  always_comb begin
    m_last = '0;
    for (int unsigned i = 0; i < 7; i++)
      if (i < 32'(msg_bytes)) m_last[8*i +: 8] = msg_data[8*i +: 8];
    m_last[63:56] = len_q + 8'(msg_bytes);
    m_beat = msg_last ? m_last : msg_data;
  end

  always_comb begin
    msg_ready    = (state_q == ABSORB) && !init;
    busy         = (state_q != IDLE) && (state_q != DONE);
    xfer         = msg_valid && msg_ready;
    digest       = digest_q;
    digest_valid = dv_q;
  end

  always_comb begin
    state_d = state_q;
    if (init) state_d = ABSORB;
    else begin
      unique case (state_q)
        ABSORB:  if (xfer) state_d = COMP;
        COMP:    if (last_step) state_d = MIX;
        MIX:     state_d = last_q ? FXOR : ABSORB;
        FXOR:    state_d = FIN;
        FIN:     if (last_step) state_d = second_q ? OUT1 : OUT0;
        OUT0:    state_d = long_q ? FIN : DONE;
        OUT1:    state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      v0_q <= '0;  v1_q <= '0;  v2_q <= '0;  v3_q <= '0;
      m_q <= '0;  len_q <= '0;  rem_q <= '0;
      last_q <= 1'b0;  long_q <= 1'b0;  second_q <= 1'b0;
      digest_q <= '0;  dv_q <= 1'b0;
    end else if (init) begin
      v0_q     <= key[63:0]   ^ 64'h736f6d6570736575;
      v1_q     <= key[127:64] ^ 64'h646f72616e646f6d ^ (long ? 64'hee : 64'h0);
      v2_q     <= key[63:0]   ^ 64'h6c7967656e657261;
      v3_q     <= key[127:64] ^ 64'h7465646279746573;
      len_q    <= '0;
      rem_q    <= '0;
      last_q   <= 1'b0;
      long_q   <= long;
      second_q <= 1'b0;
      digest_q <= '0;
      dv_q     <= 1'b0;
    end else begin
      unique case (state_q)
        ABSORB: if (xfer) begin
          v3_q   <= v3_q ^ m_beat;
          m_q    <= m_beat;
          last_q <= msg_last;
          rem_q  <= 4'(C_ROUNDS);
          if (!msg_last) len_q <= len_q + 8'd8;
        end
        COMP, FIN: begin
          {v3_q, v2_q, v1_q, v0_q} <= rnd;
          rem_q <= rem_q - step;
        end
        MIX:  v0_q <= v0_q ^ m_q;
        FXOR: begin
          v2_q  <= v2_q ^ (long_q ? 64'hee : 64'hff);
          rem_q <= 4'(D_ROUNDS);
        end
        OUT0: begin
          digest_q[63:0] <= vfin;
          if (long_q) begin
            v1_q     <= v1_q ^ 64'hdd;
            rem_q    <= 4'(D_ROUNDS);
            second_q <= 1'b1;
          end else dv_q <= 1'b1;
        end
        OUT1: begin
          digest_q[127:64] <= vfin;
          dv_q             <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SIPHASH_BLOCK_CTR_EN
  logic [31:0] blk_q;

  always_ff @(posedge clk) begin
    if (!reset_n || init)                  blk_q <= '0;
    else if (state_q == MIX && blk_q != '1) blk_q <= blk_q + 32'd1;
  end

  assign blk_cnt = blk_q;
`endif

endmodule

// File: tb/tb_siphash_stream_core.sv
// Bench for siphash_stream_core: three instances (RPC=1, RPC=2, odd rounds) against a byte-level SipHash model.
module tb_siphash_stream_core;

  localparam logic [127:0] KEY = 128'h0f0e0d0c0b0a0908_0706050403020100;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         long_s = 1'b0;
  logic [127:0] key_s = '0;
  logic [63:0]  data_s = '0;
  logic         last_s = 1'b0;
  logic [2:0]   bytes_s = '0;
  logic         init_s [3];
  logic         valid_s [3];
  logic         ready_s [3];
  logic         busy_s [3];
  logic         dv_s [3];
  logic [127:0] dig_s [3];
`ifdef SIPHASH_BLOCK_CTR_EN
  logic [31:0]  blk_s [3];
`endif

  int c_of [3] = '{2, 2, 3};
  int d_of [3] = '{4, 4, 1};
  int r_of [3] = '{1, 2, 2};

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  byte unsigned mq [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  siphash_stream_core #(.C_ROUNDS(2), .D_ROUNDS(4), .RPC(1)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .init(init_s[0]), .long(long_s), .key(key_s),
    .msg_valid(valid_s[0]), .msg_ready(ready_s[0]), .msg_data(data_s),
    .msg_last(last_s), .msg_bytes(bytes_s), .busy(busy_s[0]),
    .digest(dig_s[0]), .digest_valid(dv_s[0])
`ifdef SIPHASH_BLOCK_CTR_EN
    , .blk_cnt(blk_s[0])
`endif
  );

  siphash_stream_core #(.C_ROUNDS(2), .D_ROUNDS(4), .RPC(2)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .init(init_s[1]), .long(long_s), .key(key_s),
    .msg_valid(valid_s[1]), .msg_ready(ready_s[1]), .msg_data(data_s),
    .msg_last(last_s), .msg_bytes(bytes_s), .busy(busy_s[1]),
    .digest(dig_s[1]), .digest_valid(dv_s[1])
`ifdef SIPHASH_BLOCK_CTR_EN
    , .blk_cnt(blk_s[1])
`endif
  );

  siphash_stream_core #(.C_ROUNDS(3), .D_ROUNDS(1), .RPC(2)) u_dut2 (
    .clk(clk), .reset_n(reset_n), .init(init_s[2]), .long(long_s), .key(key_s),
    .msg_valid(valid_s[2]), .msg_ready(ready_s[2]), .msg_data(data_s),
    .msg_last(last_s), .msg_bytes(bytes_s), .busy(busy_s[2]),
    .digest(dig_s[2]), .digest_valid(dv_s[2])
`ifdef SIPHASH_BLOCK_CTR_EN
    , .blk_cnt(blk_s[2])
`endif
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] rotl(input logic [63:0] x, input int r);
    return (x << r) | (x >> (64 - r));
  endfunction

  function automatic void sip_rounds(inout logic [63:0] a, inout logic [63:0] b,
                                     inout logic [63:0] c, inout logic [63:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      a = a + b; b = rotl(b, 13); b = b ^ a; a = rotl(a, 32);
      c = c + d; d = rotl(d, 16); d = d ^ c;
      a = a + d; d = rotl(d, 21); d = d ^ a;
      c = c + b; b = rotl(b, 17); b = b ^ c; c = rotl(c, 32);
    end
  endfunction

  // Reference SipHash over the byte queue mq.
  function automatic logic [127:0] ref_sip(input logic [127:0] k, input bit lng, input int c, input int d);
    logic [63:0] v0, v1, v2, v3, m, out0, out1;
    int n;
    int nfull;
    v0 = k[63:0]   ^ 64'h736f6d6570736575;
    v1 = k[127:64] ^ 64'h646f72616e646f6d ^ (lng ? 64'hee : 64'h0);
    v2 = k[63:0]   ^ 64'h6c7967656e657261;
    v3 = k[127:64] ^ 64'h7465646279746573;
    n = mq.size();
    nfull = n / 8;
    for (int w = 0; w <= nfull; w++) begin
      m = '0;
      if (w < nfull) begin
        for (int j = 0; j < 8; j++) m[8*j +: 8] = mq[8*w + j];
      end else begin
        for (int j = 0; j < n % 8; j++) m[8*j +: 8] = mq[8*w + j];
        m[63:56] = 8'(n % 256);
      end
      v3 = v3 ^ m;
      sip_rounds(v0, v1, v2, v3, c);
      v0 = v0 ^ m;
    end
    v2 = v2 ^ (lng ? 64'hee : 64'hff);
    sip_rounds(v0, v1, v2, v3, d);
    out0 = v0 ^ v1 ^ v2 ^ v3;
    out1 = '0;
    if (lng) begin
      v1 = v1 ^ 64'hdd;
      sip_rounds(v0, v1, v2, v3, d);
      out1 = v0 ^ v1 ^ v2 ^ v3;
    end
    return {out1, out0};
  endfunction

  task automatic run_job(input int u, input bit lng, input logic [127:0] k, input bit tog,
                         input int abort_after, output logic [127:0] dg);
    int n, nb, kc, kd, tries;
    bit done;
    logic [63:0] w;
    int acc [$];
    n  = mq.size();
    nb = n / 8 + 1;
    kc = (c_of[u] + r_of[u] - 1) / r_of[u];
    kd = (d_of[u] + r_of[u] - 1) / r_of[u];
    dg = '0;
    @(negedge clk);
    key_s = k; long_s = lng; init_s[u] = 1'b1; valid_s[u] = 1'b1; last_s = 1'b0;
    data_s = {$urandom, $urandom};
    #1 check("ready_during_init", 128'(ready_s[u]), 128'(0));
    @(negedge clk);
    init_s[u] = 1'b0; valid_s[u] = 1'b0;
    check("dv_after_init", 128'(dv_s[u]), 128'(0));
    check("digest_after_init", dig_s[u], '0);
    check("busy_after_init", 128'(busy_s[u]), 128'(1));
    for (int b = 0; b < nb; b++) begin
      w = {$urandom, $urandom};
      if (b < nb - 1) begin
        for (int j = 0; j < 8; j++) w[8*j +: 8] = mq[8*b + j];
      end else begin
        for (int j = 0; j < n % 8; j++) w[8*j +: 8] = mq[8*b + j];
      end
      done = 1'b0;
      tries = 0;
      while (!done) begin
        valid_s[u] = tog ? 1'($urandom_range(0, 1)) : 1'b1;
        data_s  = w;
        last_s  = (b == nb - 1);
        bytes_s = last_s ? 3'(n % 8) : 3'($urandom_range(0, 7));
        #1;
        if (valid_s[u] && ready_s[u]) begin
          done = 1'b1;
          acc.push_back(cyc + 1);
        end
        @(negedge clk);
        if (!done && ++tries > 400) begin
          check("beat_accept_timeout", 128'(0), 128'(1));
          valid_s[u] = 1'b0;
          return;
        end
      end
    end
    valid_s[u] = 1'b0;
    if (!tog)
      for (int b = 1; b < nb; b++)
        check("block_gap", 128'(acc[b] - acc[b-1]), 128'(kc + 2));
    if (abort_after >= 0) begin
      repeat (abort_after) @(negedge clk);
      return;
    end
    tries = 0;
    while (!dv_s[u]) begin
      @(negedge clk);
      if (++tries > 400) begin
        check("digest_valid_timeout", 128'(0), 128'(1));
        return;
      end
    end
    check("latency", 128'(cyc - acc[nb-1]), 128'(kc + kd + 3 + (lng ? kd + 1 : 0)));
    check("digest_vs_model", dig_s[u], ref_sip(k, lng, c_of[u], d_of[u]));
    dg = dig_s[u];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] dg, dg2;
    for (int u = 0; u < 3; u++) begin
      init_s[u] = 1'b0;
      valid_s[u] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int u = 0; u < 3; u += 2) begin
      check("reset_digest", dig_s[u], '0);
      check("reset_dv", 128'(dv_s[u]), 128'(0));
      check("reset_busy", 128'(busy_s[u]), 128'(0));
      check("reset_ready", 128'(ready_s[u]), 128'(0));
    end
    reset_n = 1'b1;

    // Directed vectors on the C=2/D=4 instances (RPC=1 steady, RPC=2 with toggling valid).
    for (int u = 0; u < 2; u++) begin
      mq.delete();
      run_job(u, 1'b0, KEY, 1'b0, -1, dg);
      check("vec1_empty_64", dg, 128'h0000000000000000_726fdb47dd0e0e31);
      for (int i = 0; i < 15; i++) mq.push_back(8'(i));
      run_job(u, 1'b0, KEY, 1'(u), -1, dg2);
      check("vec2_15b_64", dg2, 128'h0000000000000000_a129ca6149be45e5);
`ifdef SIPHASH_BLOCK_CTR_EN
      check("blk_cnt_vec2", 128'(blk_s[u]), 128'(2));
`endif
      @(negedge clk);
      valid_s[u] = 1'b1; last_s = 1'b1; data_s = {$urandom, $urandom}; bytes_s = 3'd3;
      #1 check("ready_in_done", 128'(ready_s[u]), 128'(0));
      repeat (3) @(negedge clk);
      valid_s[u] = 1'b0;
      check("done_digest_held", dig_s[u], dg2);
      check("done_dv_held", 128'(dv_s[u]), 128'(1));
`ifdef SIPHASH_BLOCK_CTR_EN
      check("blk_cnt_done_held", 128'(blk_s[u]), 128'(2));
`endif
      mq.delete();
      run_job(u, 1'b1, KEY, 1'(u), -1, dg);
      check("vec3_empty_128", dg, 128'h930255c71472f66d_e6a825ba047f81a3);
    end

    // init during finalisation aborts the running job.
    mq.delete();
    run_job(0, 1'b1, KEY, 1'b0, 3, dg);
    check("busy_before_abort", 128'(busy_s[0]), 128'(1));
    run_job(0, 1'b0, KEY, 1'b0, -1, dg);
    check("vec5_after_abort", dg, 128'h0000000000000000_726fdb47dd0e0e31);

    // Synchronous reset while compressing.
    for (int i = 0; i < 9; i++) mq.push_back(8'($urandom));
    run_job(0, 1'b0, KEY, 1'b0, 0, dg);
    check("busy_in_comp", 128'(busy_s[0]), 128'(1));
    reset_n = 1'b0;
    @(negedge clk);
    check("midjob_reset_digest", dig_s[0], '0);
    check("midjob_reset_dv", 128'(dv_s[0]), 128'(0));
    check("midjob_reset_busy", 128'(busy_s[0]), 128'(0));
    check("midjob_reset_other_dv", 128'(dv_s[1]), 128'(0));
    check("midjob_reset_other_dig", dig_s[1], '0);
    reset_n = 1'b1;

    // Randomised jobs on every instance, plus one message long enough to wrap the length byte.
    for (int u = 0; u < 3; u++) begin
      repeat (12) begin
        mq.delete();
        repeat ($urandom_range(0, 40)) mq.push_back(8'($urandom));
        run_job(u, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom},
                1'($urandom_range(0, 1)), -1, dg);
      end
      mq.delete();
      repeat (300) mq.push_back(8'($urandom));
      run_job(u, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, 1'b0, -1, dg);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
